apb_slave_bank: RTL
===================

# apb_slave_bank

Parametrised, synthesizable APB completer bank with `NUM_SLV` independent word-addressed memories. It replaces the constant `Prdata = 0` tie-off in the AHB2APB bridge benches. It sits on the bridge's APB side, driven by `Pselx`/`Penable`/`Pwrite`/`Paddr`/`Pwdata`. It returns `Prdata`, APB3 `Pready` wait states and `Pslverr`, and flags protocol violations and transfer counts for the scoreboard.

## Interface
- `DATA_W`, 32, data width of `Pwdata`/`Prdata`.
- `ADDR_W`, 32, width of `Paddr`.
- `NUM_SLV`, 3, number of completers; width of `Pselx`.
- `DEPTH`, 16, words per completer; power of two, ≥2. `IDX_W = $clog2(DEPTH)`.
- `OFFSET_W`, 26, log2 of the byte window per completer.
- `WAIT_CYC`, 0, `Pready`-low cycles inserted per access phase; 0..15.
- `ERR_EN`, 1, 1 = out-of-window access returns `Pslverr`.
- `Pclk` in 1: APB clock; all state updates on its rising edge.
- `Hresetn` in 1: asynchronous, active-low reset.
- `Pselx` in NUM_SLV: one-hot completer select.
- `Penable` in 1: APB access phase.
- `Pwrite` in 1: 1 = write.
- `Paddr` in ADDR_W: byte address.
- `Pwdata` in DATA_W: write data.
- `Prdata` out DATA_W: read data, registered.
- `Pready` out 1: transfer completes this cycle.
- `Pslverr` out 1: error on the completing transfer.
- `proto_err` out 1: sticky protocol-violation flag.
- `wr_count` out 16: completed writes, saturating.
- `rd_count` out 16: completed reads, saturating.

## Operation
- **Address fields**
  - `Paddr[1:0]` is ignored.
  - The word index is `Paddr[IDX_W+1:2]`.
  - The transfer is out of window if any bit of `Paddr[OFFSET_W-1:IDX_W+2]` is set.
  - Bits at or above `OFFSET_W` are ignored; the bridge has already decoded them.
- **FSM states:** `IDLE`, `ACCESS`.
- **IDLE**
  - On an edge sampling `|Pselx && !Penable` (setup phase), latch:
    - the slave index (the lowest set bit);
    - the index and out-of-window error bit;
    - `Pwrite` and `Pwdata`.
  - On the same edge, load `wait_cnt = WAIT_CYC` and go to `ACCESS`.
  - For a read, the same edge loads `Prdata` with `mem[slv][idx]`, or with 0 if the transfer errors.
  - `Pselx` with more than one bit set at setup sets `proto_err`; the transfer proceeds with the lowest set bit.
  - `Penable=1` while in `IDLE` sets `proto_err`; the state does not change.
- **ACCESS**
  - `Pready = (wait_cnt == 0)`.
  - `Pslverr = Pready & err_latched & ERR_EN`.
  - On an edge where `Penable=1` and `wait_cnt != 0`: decrement `wait_cnt`.
  - On an edge where `Penable=1` and `wait_cnt == 0`: the transfer completes.
    - A write without error updates memory.
    - Increment `wr_count` or `rd_count`; this happens even when the transfer errors.
    - Return to `IDLE`.
  - The edge after the last access cycle is the next setup or idle cycle.
  - If `Penable=0`, or `Pselx`/`Paddr`/`Pwrite`/`Pwdata` differ from the latched values during `ACCESS`:
    - set `proto_err`;
    - abort with no memory update and no count;
    - go to `IDLE`.
- **Outputs outside ACCESS:** `Pready=0` and `Pslverr=0`.
- **Counters:** saturate at `16'hFFFF`; no wrap.
- **Reset values**
  - FSM `IDLE`; `Prdata=0`; `Pready=0`; `Pslverr=0`.
  - `proto_err=0`; counters 0; all memory words 0.
- **Reset mid-transfer:** immediate return to the reset values; no partial write.

## Timing
- Setup in cycle T0; `Penable=1` from T1.
- With `WAIT_CYC=N`, `Pready=1` in cycle T1+N only.
- `Prdata` is valid from T1 and holds until the next read's setup edge.
- A write is visible to a read whose setup is at T1+N+1 or later (back-to-back).
- Back-to-back transfers with no idle cycle are supported: the completion edge and the next setup edge are distinct cycles.
- `Pready` and `Pslverr` are decoded from registered state only; there is no combinational path from any input.
- `proto_err` rises on the edge after the violating cycle and clears only on reset.

## Test plan
1. Reset, then write `0xA5A5_0001` to slave 0 addr `0x8000_0008`, then read the same address, `WAIT_CYC=0`.
   - Expect `Pready=1` in each T1.
   - Expect `Prdata=0xA5A5_0001`, `wr_count=1`, `rd_count=1`, `proto_err=0`.
2. Set `WAIT_CYC=3` and write then read slave 2 at `0x8800_003C`.
   - Expect `Pready` low for 3 access cycles, high on the 4th.
   - Expect the read to return the written data.
   - Expect slave 0 and slave 1 at index 15 to still read 0.
3. Read `0x8400_0040` (out of window, `ERR_EN=1`).
   - Expect `Pslverr=1` with `Pready`.
   - Expect `Prdata=0` and `rd_count` incremented.
   - Write the same address: expect no memory word to change.
4. Protocol violations:
   - Drive `Pselx=3'b011` at setup: expect `proto_err=1` and slave 0 accessed.
   - After reset, drop `Penable` mid-access with `WAIT_CYC=2`: expect `proto_err=1` and no count.
5. Assert `Hresetn=0` while `wait_cnt=1` during a write.
   - Expect `Pready=0` immediately.
   - After release, expect a read of that address to return 0 and counters at 0.
6. Issue 65,540 back-to-back reads.
   - Expect `rd_count` to saturate at `0xFFFF`.
   - Expect each `Pready` exactly 1 cycle wide with `WAIT_CYC=0`.

Source files
------------

// File: rtl/apb_slave_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : apb_slave_bank
// Description : Bank of NUM_SLV APB3 completers, each a word-addressed memory
//               of DEPTH words. Adds WAIT_CYC wait states per access, returns
//               Pslverr for out-of-window accesses, raises a sticky protocol
//               violation flag and keeps saturating transfer counters.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_slave_bank #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int NUM_SLV  = 3,
  parameter int DEPTH    = 16,
  parameter int OFFSET_W = 26,
  parameter int WAIT_CYC = 0,
  parameter int ERR_EN   = 1
) (
  input  logic               Pclk,
  input  logic               Hresetn,
  input  logic [NUM_SLV-1:0] Pselx,
  input  logic               Penable,
  input  logic               Pwrite,
  input  logic [ADDR_W-1:0]  Paddr,
  input  logic [DATA_W-1:0]  Pwdata,
  output logic [DATA_W-1:0]  Prdata,
  output logic               Pready,
  output logic               Pslverr,
  output logic               proto_err,
  output logic [15:0]        wr_count,
  output logic [15:0]        rd_count
);

  localparam int c_IDX_W = $clog2(DEPTH);
  localparam int c_SLV_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam logic [3:0] c_WAIT = 4'(WAIT_CYC);
  localparam logic [0:0] c_IDLE   = 1'b0;
  localparam logic [0:0] c_ACCESS = 1'b1;

  logic [0:0]         r_state;
  logic [3:0]         r_wait_cnt;
  logic [c_SLV_W-1:0] r_slv;
  logic [c_IDX_W-1:0] r_idx;
  logic               r_err;
  logic               r_write;
  logic [DATA_W-1:0]  r_wdata;
  logic [NUM_SLV-1:0] r_sel;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_prdata;
  logic               r_proto_err;
  logic [15:0]        r_wr_count;
  logic [15:0]        r_rd_count;
  logic [DATA_W-1:0]  r_mem [NUM_SLV][DEPTH];

  logic [c_SLV_W-1:0] w_slv;
  logic [c_IDX_W-1:0] w_idx;
  logic               w_oow;
  logic               w_err_now;
  logic               w_multi;
  logic               w_setup;
  logic               w_viol;
  logic               w_fire;
  logic               w_mem_we;

  // Out-of-window check covers only the offset bits above the word index;
  // a window exactly DEPTH words wide has no such bits.
  if (OFFSET_W > c_IDX_W + 2) begin : g_win
    assign w_oow = |Paddr[OFFSET_W-1:c_IDX_W+2];
  end else begin : g_nowin
    assign w_oow = 1'b0;
  end

  assign w_idx     = Paddr[c_IDX_W+1:2];
  assign w_err_now = w_oow && (ERR_EN != 0);
  assign w_multi   = |(Pselx & (Pselx - NUM_SLV'(1)));
  assign w_setup   = (|Pselx) && !Penable;
  // Any change of the bus while in the access phase aborts the transfer.
  assign w_viol    = !Penable || (Pselx != r_sel) || (Paddr != r_addr) ||
                     (Pwrite != r_write) || (Pwdata != r_wdata);
  assign w_fire    = (r_state == c_ACCESS) && !w_viol && (r_wait_cnt == 4'd0);
  assign w_mem_we  = w_fire && r_write && !r_err;

  assign Prdata    = r_prdata;
  assign Pready    = (r_state == c_ACCESS) && (r_wait_cnt == 4'd0);
  assign Pslverr   = Pready && r_err;
  assign proto_err = r_proto_err;
  assign wr_count  = r_wr_count;
  assign rd_count  = r_rd_count;

  // Lowest set select bit picks the completer when several are asserted.
  always_comb begin
    w_slv = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if (Pselx[i]) w_slv = c_SLV_W'(i);
    end
  end

  // Transfer FSM: latch setup, count wait states, complete or abort.
  always_ff @(posedge Pclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_state     <= c_IDLE;
      r_wait_cnt  <= 4'd0;
      r_slv       <= '0;
      r_idx       <= '0;
      r_err       <= 1'b0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_sel       <= '0;
      r_addr      <= '0;
      r_prdata    <= '0;
      r_proto_err <= 1'b0;
      r_wr_count  <= 16'd0;
      r_rd_count  <= 16'd0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_setup) begin
            r_slv      <= w_slv;
            r_idx      <= w_idx;
            r_err      <= w_err_now;
            r_write    <= Pwrite;
            r_wdata    <= Pwdata;
            r_sel      <= Pselx;
            r_addr     <= Paddr;
            r_wait_cnt <= c_WAIT;
            r_state    <= c_ACCESS;
            if (!Pwrite) r_prdata <= w_err_now ? '0 : r_mem[w_slv][w_idx];
            if (w_multi) r_proto_err <= 1'b1;
          end else if (Penable) begin
            r_proto_err <= 1'b1;
          end
        end
        c_ACCESS: begin
          if (w_viol) begin
            r_proto_err <= 1'b1;
            r_state     <= c_IDLE;
          end else if (r_wait_cnt != 4'd0) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end else begin
            if (r_write) begin
              if (r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 16'd1;
            end else begin
              if (r_rd_count != 16'hFFFF) r_rd_count <= r_rd_count + 16'd1;
            end
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // Completer memories: written only by a completing, error-free write.
  always_ff @(posedge Pclk or negedge Hresetn) begin
    if (!Hresetn) begin
      for (int s = 0; s < NUM_SLV; s++) begin
        for (int d = 0; d < DEPTH; d++) begin
          r_mem[s][d] <= '0;
        end
      end
    end else if (w_mem_we) begin
      r_mem[r_slv][r_idx] <= r_wdata;
    end
  end

endmodule
`default_nettype wire
